ssd_multi_digit_entry: RTL and testbench
========================================

# ssd_multi_digit_entry

Keyboard-driven, multiplexed seven-segment display controller. It accepts decoded PS/2 key events, keeps a right-aligned buffer of up to `DIGITS` glyphs, and scans them onto a shared segment bus with active-low digit enables. It sits between the keyboard decoder (which supplies `last_change`/`key_valid`) and the board's seven-segment pins, and generalises the single-digit key echo to N digits with shift-in, operator, enter and backspace handling.

## Interface
- `DIGITS`, 4: number of display digits (2..8); digit 0 is rightmost/newest.
- `SCAN_DIV`, 16'd50000: clock cycles each digit stays enabled (≥2).
- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock, asynchronous, active-high.
- `last_change`  in  9  scan code of the most recent key; bit 8 = extended flag.
- `key_valid`  in  1  one-cycle pulse: `last_change` holds a new press this cycle.
- `display`  out  8  segments {a,b,c,d,e,f,g,dp}, active-low, registered.
- `ctrl`  out  DIGITS  digit enables, active-low one-hot or all-ones, registered.

## Operation
- Key classes; only evaluated when `key_valid`=1 and `last_change[8]`=0. Other codes are ignored with no state change:
  - NUM: 0x45,16,1E,26,25,2E,36,3D,3E,46 map to 0..9.
  - OP: 0x1C A, 0x1B S, 0x3A M.
  - ENTER: 0x5A.
  - BKSP: 0x66.
- Glyphs use the team's active-low table, with dp=1 always: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, S=0100101, M=0101010.
- State machine `{IDLE, NUM, OP}`; reset → IDLE. Buffer `buf[DIGITS]` and `count` (0..DIGITS), both reset to 0.
  - IDLE / OP + NUM: clear buffer, `buf[0]`=digit, `count`=1 → NUM.
  - NUM + NUM: shift `buf[i]`←`buf[i-1]`, `buf[0]`=digit, `count`=min(count+1, DIGITS). The oldest digit drops off at full.
  - any + OP: clear buffer, `buf[0]`=op glyph, `count`=1 → OP.
  - OP + ENTER: `count`=0 → IDLE. ENTER in IDLE or NUM is ignored.
  - NUM + BKSP: shift right (`buf[i]`←`buf[i+1]`, top cleared), `count`-1. If the result is 0 → IDLE. BKSP in IDLE or OP is ignored.
- Scanner:
  - `scan_cnt` runs 0..SCAN_DIV-1 and wraps.
  - On wrap, `digit_idx` advances 0..DIGITS-1 and wraps to 0.
  - Both counters reset to 0 and run independently of key events.
- Output register, loaded every cycle:
  - If `digit_idx` < `count`: `display`=`buf[digit_idx]`, `ctrl`=~(1<<`digit_idx`).
  - Otherwise: `display`=8'hFF, `ctrl`=all ones (blank digit, no ghosting).
- Reset values: `display`=8'hFF, `ctrl`={DIGITS{1'b1}}, state IDLE.

## Timing
- Key applied at edge t: buffer, `count` and state update at edge t+1. Outputs reflect the new buffer at edge t+2 if that digit is being scanned, otherwise at its next scan slot.
- Each digit is enabled for exactly SCAN_DIV cycles. Full refresh period = DIGITS×SCAN_DIV cycles.
- Output latency from `digit_idx` change is 1 cycle. `display` and `ctrl` always change on the same edge.
- Back-to-back `key_valid` pulses on consecutive cycles are all processed in order; none are dropped.
- Reset asserted mid-scan or mid-entry: all outputs blank immediately (asynchronously). On release, the scan restarts at digit 0.

## Configuration
- `SSD_BACKSPACE_EN`:
  - Defined: BKSP behaves as described above.
  - Undefined: 0x66 is treated as an unknown code and ignored, and the shift-right path is not synthesised.

## Structure
- Shared package `ssd_pkg`:
  - glyph constants `SSD_0`..`SSD_9`, `SSD_A`, `SSD_S`, `SSD_M`, `SSD_BLANK`;
  - scan-code constants `KEY_0`..`KEY_9`, `KEY_ADD`, `KEY_SUB`, `KEY_MUL`, `KEY_ENTER`, `KEY_BKSP`;
  - state encoding `ST_IDLE`, `ST_NUM`, `ST_OP`.
- One sub-module, `ssd_key_classify`: combinational; from `last_change` it produces `is_num`, `is_op`, `is_enter`, `is_bksp` and `glyph[7:0]`. The parent holds the FSM, buffer, scanner and output register.

## Test plan
- Reset, no keys → `display`=8'hFF and `ctrl`=4'hF throughout two full refresh periods.
- Keys 1,2,3 (DIGITS=4, SCAN_DIV=4) → digit0 shows 3 (0000110_1), digit1 shows 2, digit2 shows 1; `ctrl`=1110/1101/1011; slot 3 is blank with `ctrl`=1111.
- Keys 1..6 → buffer holds 6,5,4,3 (digit0..3) and `count` saturates at 4; all four slots are lit.
- Keys 7, 0x1C, then 0x5A → after 0x1C only digit0 shows A (0001000_1); after ENTER all slots are blank and the state is IDLE.
- With `SSD_BACKSPACE_EN`: keys 4,5 then 0x66 → only digit0 shows 4. A second 0x66 → all blank, state IDLE. Without the macro, 0x66 leaves 4,5 displayed.
- Assert `rst` mid-slot while `ctrl`=1101 → `ctrl`=1111 and `display`=FF the same cycle; after release, the first lit slot is digit0.

Source files
------------

// File: rtl/ssd_pkg.sv
// Shared constants for the keyboard-driven seven-segment display: glyphs, scan codes, FSM states.
// Latency: none (constants and types only).
// Backpressure: none.
package ssd_pkg;

  // Active-low segment glyphs {a,b,c,d,e,f,g,dp}; dp is always off (1).
  localparam logic [7:0] SSD_0     = 8'b0000001_1;
  localparam logic [7:0] SSD_1     = 8'b1001111_1;
  localparam logic [7:0] SSD_2     = 8'b0010010_1;
  localparam logic [7:0] SSD_3     = 8'b0000110_1;
  localparam logic [7:0] SSD_4     = 8'b1001100_1;
  localparam logic [7:0] SSD_5     = 8'b0100100_1;
  localparam logic [7:0] SSD_6     = 8'b0100000_1;
  localparam logic [7:0] SSD_7     = 8'b0001111_1;
  localparam logic [7:0] SSD_8     = 8'b0000000_1;
  localparam logic [7:0] SSD_9     = 8'b0000100_1;
  localparam logic [7:0] SSD_A     = 8'b0001000_1;
  localparam logic [7:0] SSD_S     = 8'b0100101_1;
  localparam logic [7:0] SSD_M     = 8'b0101010_1;
  localparam logic [7:0] SSD_BLANK = 8'hFF;

  // PS/2 set-2 make codes (non-extended); bit 8 of last_change is checked separately.
  localparam logic [7:0] KEY_0     = 8'h45;
  localparam logic [7:0] KEY_1     = 8'h16;
  localparam logic [7:0] KEY_2     = 8'h1E;
  localparam logic [7:0] KEY_3     = 8'h26;
  localparam logic [7:0] KEY_4     = 8'h25;
  localparam logic [7:0] KEY_5     = 8'h2E;
  localparam logic [7:0] KEY_6     = 8'h36;
  localparam logic [7:0] KEY_7     = 8'h3D;
  localparam logic [7:0] KEY_8     = 8'h3E;
  localparam logic [7:0] KEY_9     = 8'h46;
  localparam logic [7:0] KEY_ADD   = 8'h1C;
  localparam logic [7:0] KEY_SUB   = 8'h1B;
  localparam logic [7:0] KEY_MUL   = 8'h3A;
  localparam logic [7:0] KEY_ENTER = 8'h5A;
  localparam logic [7:0] KEY_BKSP  = 8'h66;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NUM  = 2'd1,
    ST_OP   = 2'd2
  } state_t;

endpackage

// File: rtl/ssd_key_classify.sv
// Classifies a PS/2 scan code into digit/operator/enter/backspace and returns its glyph.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller qualifies the outputs with key_valid.
module ssd_key_classify
  import ssd_pkg::*;
(
  input  logic [8:0] last_change,
  output logic       is_num,
  output logic       is_op,
  output logic       is_enter,
  output logic       is_bksp,
  output logic [7:0] glyph
);

  // Decode only non-extended codes; everything else falls through as "no class".
  always_comb begin
    is_num   = 1'b0;
    is_op    = 1'b0;
    is_enter = 1'b0;
    is_bksp  = 1'b0;
    glyph    = SSD_BLANK;
    if (!last_change[8]) begin
      case (last_change[7:0])
        KEY_0:     begin is_num = 1'b1; glyph = SSD_0; end
        KEY_1:     begin is_num = 1'b1; glyph = SSD_1; end
        KEY_2:     begin is_num = 1'b1; glyph = SSD_2; end
        KEY_3:     begin is_num = 1'b1; glyph = SSD_3; end
        KEY_4:     begin is_num = 1'b1; glyph = SSD_4; end
        KEY_5:     begin is_num = 1'b1; glyph = SSD_5; end
        KEY_6:     begin is_num = 1'b1; glyph = SSD_6; end
        KEY_7:     begin is_num = 1'b1; glyph = SSD_7; end
        KEY_8:     begin is_num = 1'b1; glyph = SSD_8; end
        KEY_9:     begin is_num = 1'b1; glyph = SSD_9; end
        KEY_ADD:   begin is_op  = 1'b1; glyph = SSD_A; end
        KEY_SUB:   begin is_op  = 1'b1; glyph = SSD_S; end
        KEY_MUL:   begin is_op  = 1'b1; glyph = SSD_M; end
        KEY_ENTER: is_enter = 1'b1;
`ifdef SSD_BACKSPACE_EN
        KEY_BKSP:  is_bksp  = 1'b1;
`endif
        default:   ;
      endcase
    end
  end

endmodule

// File: rtl/ssd_multi_digit_entry.sv
// Multi-digit key-entry buffer scanned onto a multiplexed active-low seven-segment display.
// Latency: key at edge t -> buffer at t+1 -> outputs at t+2 when that digit is in its scan slot.
// Backpressure: none; every key_valid pulse is consumed. Optional backspace via SSD_BACKSPACE_EN.
module ssd_multi_digit_entry
  import ssd_pkg::*;
#(
  parameter int          DIGITS   = 4,
  parameter logic [15:0] SCAN_DIV = 16'd50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [8:0]        last_change,
  input  logic              key_valid,
  output logic [7:0]        display,
  output logic [DIGITS-1:0] ctrl
);

  localparam int CW = $clog2(DIGITS + 1);
  localparam int IW = $clog2(DIGITS);

  logic          is_num;
  logic          is_op;
  logic          is_enter;
  logic          is_bksp;
  logic [7:0]    glyph;

  state_t        state;
  logic [CW-1:0] count;
  logic [7:0]    digit_buf [DIGITS];
  logic [15:0]   scan_cnt;
  logic [IW-1:0] digit_idx;

  ssd_key_classify u_classify (
    .last_change (last_change),
    .is_num      (is_num),
    .is_op       (is_op),
    .is_enter    (is_enter),
    .is_bksp     (is_bksp),
    .glyph       (glyph)
  );

`ifndef SSD_BACKSPACE_EN
  // Backspace never decodes in this build; keep the port tied off cleanly.
  logic unused_bksp;
  assign unused_bksp = is_bksp;
`endif

  // Entry FSM: shifts digits in, replaces with operators, clears on enter, optionally backspaces.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      count <= '0;
      for (int i = 0; i < DIGITS; i++) digit_buf[i] <= '0;
    end else if (key_valid) begin
      if (is_num) begin
        if (state == ST_NUM) begin
          for (int i = DIGITS - 1; i > 0; i--) digit_buf[i] <= digit_buf[i-1];
          digit_buf[0] <= glyph;
          if (count < CW'(DIGITS)) count <= count + 1'b1;
        end else begin
          for (int i = 1; i < DIGITS; i++) digit_buf[i] <= '0;
          digit_buf[0] <= glyph;
          count        <= CW'(1);
          state        <= ST_NUM;
        end
      end else if (is_op) begin
        for (int i = 1; i < DIGITS; i++) digit_buf[i] <= '0;
        digit_buf[0] <= glyph;
        count        <= CW'(1);
        state        <= ST_OP;
      end else if (is_enter && state == ST_OP) begin
        count <= '0;
        state <= ST_IDLE;
      end
`ifdef SSD_BACKSPACE_EN
      else if (is_bksp && state == ST_NUM) begin
        for (int i = 0; i < DIGITS - 1; i++) digit_buf[i] <= digit_buf[i+1];
        digit_buf[DIGITS-1] <= '0;
        count               <= count - 1'b1;
        if (count == CW'(1)) state <= ST_IDLE;
      end
`endif
    end
  end

  // Scan timer: each digit owns SCAN_DIV cycles, then the index moves to the next digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (scan_cnt == SCAN_DIV - 16'd1) begin
      scan_cnt  <= '0;
      digit_idx <= (digit_idx == IW'(DIGITS - 1)) ? '0 : digit_idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 16'd1;
    end
  end

  // Output register: light the scanned digit only if it holds a glyph, otherwise blank everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      display <= SSD_BLANK;
      ctrl    <= '1;
    end else if (CW'(digit_idx) < count) begin
      display <= digit_buf[digit_idx];
      ctrl    <= ~(DIGITS'(1) << digit_idx);
    end else begin
      display <= SSD_BLANK;
      ctrl    <= '1;
    end
  end

endmodule

// File: tb/tb_ssd_multi_digit_entry.sv
// Bench for ssd_multi_digit_entry with DIGITS=4, SCAN_DIV=4: key-sequence vectors with scan-slot scoreboard.
// Latency: expectations are sampled on falling edges, one full refresh frame per vector.
// Backpressure: not applicable.
module tb_ssd_multi_digit_entry
  import ssd_pkg::*;
;
  localparam int          DIGITS   = 4;
  localparam logic [15:0] SCAN_DIV = 16'd4;
  localparam int          FRAME    = 16;
  localparam int          NV       = 16;

  // Independent glyph table (active-low abcdefg, dp=1).
  localparam logic [7:0] G0 = 8'h03, G1 = 8'h9F, G2 = 8'h25, G3 = 8'h0D, G4 = 8'h99;
  localparam logic [7:0] G5 = 8'h49, G6 = 8'h41, G7 = 8'h1F, G8 = 8'h01, G9 = 8'h09;
  localparam logic [7:0] GA = 8'h11, GS = 8'h4B, GM = 8'h55, BL = 8'hFF;

  localparam logic [8:0] K0 = 9'h045, K1 = 9'h016, K2 = 9'h01E, K3 = 9'h026, K4 = 9'h025;
  localparam logic [8:0] K5 = 9'h02E, K6 = 9'h036, K7 = 9'h03D, K8 = 9'h03E, K9 = 9'h046;
  localparam logic [8:0] KA = 9'h01C, KS = 9'h01B, KM = 9'h03A, KEN = 9'h05A, KBS = 9'h066;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [8:0]  last_change = '0;
  logic        key_valid = 1'b0;
  logic [7:0]  display;
  logic [3:0]  ctrl;

  ssd_multi_digit_entry #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk         (clk),
    .rst         (rst),
    .last_change (last_change),
    .key_valid   (key_valid),
    .display     (display),
    .ctrl        (ctrl)
  );

  always #5 clk = ~clk;

  // Edges since reset release; slot s is visible after edge k when ((k-1)/SCAN_DIV)%DIGITS == s.
  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0] disp;
    logic [3:0] ctrl;
  } obs_t;
  obs_t sb[$];

  typedef struct packed {
    logic [3:0]      nk;
    logic [9:0][8:0] keys;
    logic [3:0][7:0] disp;
    logic [2:0]      lit;
  } vec_t;
  vec_t vecs [NV];

  function automatic vec_t mk(input int lit, input logic [7:0] d0, d1, d2, d3, input int nk,
                              input logic [8:0] k0 = 0, k1 = 0, k2 = 0, k3 = 0, k4 = 0,
                              input logic [8:0] k5 = 0, k6 = 0, k7 = 0, k8 = 0, k9 = 0);
    vec_t v;
    v.lit = 3'(lit);
    v.nk  = 4'(nk);
    v.disp[0] = d0; v.disp[1] = d1; v.disp[2] = d2; v.disp[3] = d3;
    v.keys[0] = k0; v.keys[1] = k1; v.keys[2] = k2; v.keys[3] = k3; v.keys[4] = k4;
    v.keys[5] = k5; v.keys[6] = k6; v.keys[7] = k7; v.keys[8] = k8; v.keys[9] = k9;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] d, input logic [3:0] c,
                       input logic [7:0] ed, input logic [3:0] ec);
    checks++;
    if (d !== ed || c !== ec) begin
      errors++;
      $display("FAIL %s: display=%h ctrl=%b, required display=%h ctrl=%b", name, d, c, ed, ec);
    end
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    key_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive_key(input logic [8:0] k);
    @(negedge clk);
    last_change = k;
    key_valid = 1'b1;
  endtask

  task automatic drive_idle;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  // Align to slot 0 of the scan frame, then pop and compare one expectation per slot.
  task automatic observe_frame(input string name);
    int   guard;
    obs_t e;
    guard = 0;
    while (((cyc - 1) % FRAME) != 1 && guard < 3 * FRAME) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 3 * FRAME) begin
      checks++;
      errors++;
      $display("FAIL %s align: scan slot 0 not reached within %0d cycles", name, guard);
      sb.delete();
    end else begin
      for (int s = 0; s < DIGITS; s++) begin
        e = sb.pop_front();
        check($sformatf("%s slot%0d", name, s), display, ctrl, e.disp, e.ctrl);
        repeat (int'(SCAN_DIV)) @(negedge clk);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t e;
    int   guard;

    vecs[0]  = mk(0, BL, BL, BL, BL, 0);
    vecs[1]  = mk(3, G3, G2, G1, BL, 3, K1, K2, K3);
    vecs[2]  = mk(4, G6, G5, G4, G3, 6, K1, K2, K3, K4, K5, K6);
    vecs[3]  = mk(1, GA, BL, BL, BL, 2, K7, KA);
    vecs[4]  = mk(0, BL, BL, BL, BL, 3, K7, KA, KEN);
    vecs[5]  = mk(1, G1, BL, BL, BL, 4, K7, KA, KEN, K1);
`ifdef SSD_BACKSPACE_EN
    vecs[6]  = mk(1, G4, BL, BL, BL, 3, K4, K5, KBS);
    vecs[7]  = mk(0, BL, BL, BL, BL, 4, K4, K5, KBS, KBS);
    vecs[14] = mk(2, G2, G1, BL, BL, 4, K1, K2, K3, KBS);
`else
    vecs[6]  = mk(2, G5, G4, BL, BL, 3, K4, K5, KBS);
    vecs[7]  = mk(2, G5, G4, BL, BL, 4, K4, K5, KBS, KBS);
    vecs[14] = mk(3, G3, G2, G1, BL, 4, K1, K2, K3, KBS);
`endif
    vecs[8]  = mk(1, G2, BL, BL, BL, 2, 9'h116, K2);
    vecs[9]  = mk(2, G2, G1, BL, BL, 3, K1, 9'h029, K2);
    vecs[10] = mk(1, G3, BL, BL, BL, 4, K1, K2, KS, K3);
    vecs[11] = mk(2, G9, G8, BL, BL, 3, K8, KEN, K9);
    vecs[12] = mk(1, GM, BL, BL, BL, 1, KM);
    vecs[13] = mk(4, G0, G9, G8, G7, 10, K1, K2, K3, K4, K5, K6, K7, K8, K9, K0);
    vecs[15] = mk(1, GS, BL, BL, BL, 3, K1, KS, KBS);

    // Idle after reset: blank for two full refresh periods.
    do_reset();
    for (int i = 0; i < 2 * FRAME; i++) begin
      check($sformatf("reset idle cyc%0d", i), display, ctrl, BL, 4'hF);
      @(negedge clk);
    end

    // Table-driven key sequences, keys sent back-to-back on consecutive cycles.
    for (int v = 0; v < NV; v++) begin
      do_reset();
      for (int j = 0; j < int'(vecs[v].nk); j++) drive_key(vecs[v].keys[j]);
      drive_idle();
      for (int s = 0; s < DIGITS; s++) begin
        e.disp = (s < int'(vecs[v].lit)) ? vecs[v].disp[s] : BL;
        e.ctrl = (s < int'(vecs[v].lit)) ? ~(4'b0001 << s) : 4'hF;
        sb.push_back(e);
      end
      repeat (3) @(negedge clk);
      observe_frame($sformatf("vec%0d", v));
    end

    // Operator then enter: state must pass through OP and land in IDLE.
    do_reset();
    drive_key(K7);
    drive_key(KA);
    drive_idle();
    checks++;
    if (dut.state !== ST_OP) begin
      errors++;
      $display("FAIL state after op: got %0d, required %0d", dut.state, ST_OP);
    end
    drive_key(KEN);
    drive_idle();
    checks++;
    if (dut.state !== ST_IDLE) begin
      errors++;
      $display("FAIL state after enter: got %0d, required %0d", dut.state, ST_IDLE);
    end

    // Reset asserted mid-slot while digit1 is lit: outputs blank asynchronously.
    do_reset();
    drive_key(K1);
    drive_key(K2);
    drive_idle();
    guard = 0;
    while (ctrl !== 4'b1101 && guard < 3 * FRAME) begin
      @(negedge clk);
      guard++;
    end
    check("digit1 lit before reset", display, ctrl, G1, 4'b1101);
    rst = 1'b1;
    #1;
    check("async reset blank", display, ctrl, BL, 4'hF);
    @(negedge clk);
    rst = 1'b0;
    last_change = K1;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    check("post reset edge1 blank", display, ctrl, BL, 4'hF);
    @(negedge clk);
    check("post reset digit0 first", display, ctrl, G1, 4'b1110);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
